// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrated mux with a registered output stage.
// Several producers share one consumer. Each channel and the output use a
// valid/ready handshake.
//
// Optional feature: define RR_ARB_MUX_LOCK_EN to add in_lock. A granted channel
// with in_lock set keeps exclusive ownership until it sends a word with in_lock clear.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   [N]        per-channel request
//   in_data    [N*WIDTH]  channel i data at [i*WIDTH +: WIDTH]
//   in_lock    [N]        (RR_ARB_MUX_LOCK_EN only) hold the grant for a burst
//   in_ready   [N]        combinational one-hot accept strobe
//   out_valid  output register holds a word
//   out_data   [WIDTH]    output word
//   out_sel    [SELW]     index of the channel that produced out_data
//   out_ready  consumer accepts out_data this cycle
module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]         in_lock,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  // One extra bit so ptr + k cannot overflow before the wrap test.
  localparam int unsigned PW = SELW + 1;

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     req;
  logic [SELW-1:0]  gnt;
  logic [PW-1:0]    cand;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  ptr_inc;

`ifdef RR_ARB_MUX_LOCK_EN
  logic             locked;
  logic [SELW-1:0]  lock_ch;

  // While locked, only the owning channel may compete.
  always_comb begin
    req = '0;
    if (locked) begin
      req[lock_ch] = in_valid[lock_ch];
    end else begin
      req = in_valid;
    end
  end
`else
  assign req = in_valid;
`endif

  // Rotating priority scan starting at ptr, with explicit wrap at N.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'(ptr) + PW'(k);
      if (cand >= PW'(N)) begin
        cand = cand - PW'(N);
      end
      if (!found && req[cand[SELW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[SELW-1:0];
      end
    end
  end

  assign load    = found && (!out_valid || out_ready) && !rst;
  assign ptr_inc = (gnt == SELW'(N - 1)) ? '0 : gnt + SELW'(1);

  // Accept strobe and data select for the granted channel.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    if (load) begin
      in_ready[gnt] = 1'b1;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register, rotation pointer and burst lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_sel   <= gnt;
`ifdef RR_ARB_MUX_LOCK_EN
      if (in_lock[gnt]) begin
        locked  <= 1'b1;
        lock_ch <= gnt;
        // Mid-burst beats leave ptr alone; the closing beat advances it.
        if (!locked) begin
          ptr <= ptr_inc;
        end
      end else begin
        locked <= 1'b0;
        ptr    <= ptr_inc;
      end
`else
      ptr       <= ptr_inc;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]   in_lock;
  logic [2:0]     b_in_lock;
`endif

  // Second instance: three channels, 8-bit data.
  logic [2:0]     b_in_valid;
  logic [23:0]    b_in_data;
  logic [2:0]     b_in_ready;
  logic           b_out_valid;
  logic [7:0]     b_out_data;
  logic [1:0]     b_out_sel;
  logic           b_out_ready;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock(in_lock),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(8), .N(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock(b_in_lock),
`endif
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state for the 4-channel instance.
  int         m_ptr = 0;
  bit         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int         m_sel = 0;
  bit         m_locked = 1'b0;
  int         m_lock_ch = 0;

  // Compare outputs against the model, then advance the model by one clock.
  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      bit ld;
      bit lk;
      logic [N-1:0] exp_rdy;
      g = -1;
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (g < 0 && in_valid[c] && (!m_locked || c == m_lock_ch)) g = c;
        end
      end
      ld = (g >= 0) && (!m_valid || out_ready);
      exp_rdy = '0;
      if (ld) exp_rdy[g] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_sel", 64'(out_sel), 64'(m_sel));
      lk = 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
      if (ld) lk = in_lock[g];
`endif
      if (rst) begin
        m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0; m_locked = 0; m_lock_ch = 0;
      end else if (ld) begin
        m_valid = 1'b1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        if (lk) begin
          if (!m_locked) m_ptr = (g + 1) % N;
          m_locked = 1'b1;
          m_lock_ch = g;
        end else begin
          m_locked = 1'b0;
          m_ptr = (g + 1) % N;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(32'hA0 + i);
    out_ready = 1'b1;
    b_in_valid = 3'b111;
    for (int i = 0; i < 3; i++) b_in_data[i*8 +: 8] = 8'(8'hA0 + i);
    b_out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    in_lock = '0;
    b_in_lock = '0;
`endif

    // Reset held two cycles with every channel requesting.
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_sel", 64'(out_sel), 64'd0);
    chk("rst b_in_ready", 64'(b_in_ready), 64'd0);
    chk("rst b_out_valid", 64'(b_out_valid), 64'd0);

    // All valid: strict rotation on both instances, including the 2->0 wrap for N=3.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr sel", 64'(out_sel), 64'(k % 4));
      chk("rr data", 64'(out_data), 64'(32'hA0 + k % 4));
      chk("n3 sel", 64'(b_out_sel), 64'(k % 3));
      chk("n3 data", 64'(b_out_data), 64'(8'hA0 + k % 3));
    end

    // Stall: output frozen, nothing accepted; release loads the next channel at once.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall sel", 64'(out_sel), 64'd0);
      chk("stall data", 64'(out_data), 64'(32'hA0));
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 64'(in_ready), 64'b0010);
    tick();
    chk("release sel", 64'(out_sel), 64'd1);

    // Lone requester keeps winning; then priority resumes after it.
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("solo sel", 64'(out_sel), 64'd2);
    end
    in_valid = 4'b1001;
    tick();
    chk("after solo sel", 64'(out_sel), 64'd3);
    tick();
    chk("after solo sel2", 64'(out_sel), 64'd0);
    in_valid = '0;
    tick();
    chk("drain valid", 64'(out_valid), 64'd0);
    chk("drain sel held", 64'(out_sel), 64'd0);

`ifdef RR_ARB_MUX_LOCK_EN
    // Four-beat locked burst from ch1 with ch0 and ch2 also requesting.
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b0001; tick();
    in_valid = 4'b0111; in_lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lock beat", 64'(out_sel), 64'd1);
    end
    in_lock = '0;
    tick();
    chk("lock last beat", 64'(out_sel), 64'd1);
    tick();
    chk("after unlock", 64'(out_sel), 64'd2);

    // Reset in mid-burst drops the lock.
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 4'b0001; tick();
    in_valid = 4'b0111; in_lock = 4'b0010;
    tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; in_lock = '0;
    tick();
    chk("lock reset sel", 64'(out_sel), 64'd0);
`endif

    // Random traffic; the model checks every cycle.
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      in_valid = N'($urandom);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_ARB_MUX_LOCK_EN
      in_lock = N'($urandom) & N'($urandom);
`endif
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
